// File: rtl/e06_response_checker_pkg.sv
// Shared state encoding and sizing for the response checker and its truth ROM.
package e06_response_checker_pkg;

   localparam int CODE_W  = 4;
   localparam int RESP_W  = 3;
   localparam int N_CODES = 16;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DRIVE  = 3'd1,
      S_SETTLE = 3'd2,
      S_SAMPLE = 3'd3,
      S_DONE   = 3'd4
   } state_t;

endpackage

// File: rtl/e06_truth_rom.sv
// Combinational lookup of the expected {f,g,h} response for one input code.
module e06_truth_rom
   import e06_response_checker_pkg::*;
#(
   parameter logic [RESP_W*N_CODES-1:0] EXP_TABLE = '0
) (
   input  logic [CODE_W-1:0] code,
   output logic [RESP_W-1:0] exp_resp
);

   assign exp_resp = EXP_TABLE[RESP_W*code +: RESP_W];

endmodule

// File: rtl/e06_response_checker.sv
// Sweeps all 16 codes onto a..d, samples f,g,h after a settle interval and
// tallies mismatches against a parameterised truth table.
module e06_response_checker
   import e06_response_checker_pkg::*;
#(
   parameter logic [RESP_W*N_CODES-1:0] EXP_TABLE     = '0,
   parameter int                        SETTLE_CYCLES = 2,
   parameter bit                        LOOP          = 1'b0
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       start,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       d,
   input  logic       f,
   input  logic       g,
   input  logic       h,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [4:0] err_count,
   output logic       first_err_valid,
   output logic [3:0] first_err_code
);

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
   localparam logic [CODE_W-1:0] LAST_CODE = CODE_W'(N_CODES - 1);

   state_t              state;
   logic [CODE_W-1:0]   code;
   logic [CODE_W-1:0]   stim;
   logic [3:0]          settle_cnt;
   logic [RESP_W-1:0]   exp_resp;
   logic                mismatch;
   logic [4:0]          err_nxt;
   logic                launch;

   e06_truth_rom #(
      .EXP_TABLE (EXP_TABLE)
   ) u_rom (
      .code     (code),
      .exp_resp (exp_resp)
   );

   assign {a, b, c, d} = stim;
   assign mismatch     = ({f, g, h} != exp_resp);
   assign err_nxt      = err_count + 5'(mismatch);

   // A sweep begins from IDLE on start, or from DONE on start / automatically when looping.
   assign launch = ((state == S_IDLE) && start) ||
                   ((state == S_DONE) && (start || LOOP));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state           <= S_IDLE;
         code            <= '0;
         stim            <= '0;
         settle_cnt      <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         pass            <= 1'b0;
         err_count       <= '0;
         first_err_valid <= 1'b0;
         first_err_code  <= '0;
      end else if (launch) begin
         state           <= S_DRIVE;
         code            <= '0;
         busy            <= 1'b1;
         done            <= 1'b0;
         pass            <= 1'b0;
         err_count       <= '0;
         first_err_valid <= 1'b0;
         first_err_code  <= '0;
      end else begin
         case (state)
            S_DRIVE: begin
               stim       <= code;
               settle_cnt <= SETTLE_LOAD;
               busy       <= 1'b1;
               state      <= S_SETTLE;
            end
            S_SETTLE: begin
               if (settle_cnt == 4'd0) state <= S_SAMPLE;
               else                    settle_cnt <= settle_cnt - 4'd1;
            end
            S_SAMPLE: begin
               if (mismatch) begin
                  err_count <= err_nxt;
                  if (!first_err_valid) begin
                     first_err_valid <= 1'b1;
                     first_err_code  <= code;
                  end
               end
               // The last code ends the sweep; the code register stays at 15.
               if (code == LAST_CODE) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_nxt == 5'd0);
               end else begin
                  code  <= code + 1'b1;
                  state <= S_DRIVE;
               end
            end
            S_IDLE, S_DONE: ;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_e06_response_checker.sv
// Scoreboard bench: a faultable model of the unit under test drives f,g,h back.
module tb_e06_response_checker;

   function automatic logic [2:0] golden(input logic [3:0] k);
      return {k[3] & k[2], k[1] | k[0], k[3] ^ k[0]};
   endfunction

   function automatic logic [47:0] build_table();
      logic [47:0] t;
      t = '0;
      for (int k = 0; k < 16; k++) t[3*k +: 3] = golden(4'(k));
      return t;
   endfunction

   localparam logic [47:0] EXP = build_table();

   typedef struct {
      int     errs;
      bit     fev;
      int     fcode;
      bit     pass;
      longint done_cyc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // Main instance: LOOP=0, SETTLE_CYCLES=2
   logic rstn, start, a, b, c, d, f, g, h, busy, done, pass, fev;
   logic [4:0] err_count;
   logic [3:0] fec;
   logic [2:0] fault_mask [16];
   logic       stuck_h;

   e06_response_checker #(.EXP_TABLE(EXP), .SETTLE_CYCLES(2), .LOOP(1'b0)) dut (
      .clk(clk), .rstn(rstn), .start(start), .a(a), .b(b), .c(c), .d(d),
      .f(f), .g(g), .h(h), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .first_err_valid(fev), .first_err_code(fec));

   always_comb begin
      logic [2:0] r;
      r = golden({a, b, c, d}) ^ fault_mask[{a, b, c, d}];
      if (stuck_h) r[0] = 1'b0;
      {f, g, h} = r;
   end

   // Second instance: LOOP=1, SETTLE_CYCLES=1, fault-free unit
   logic rstn2, start2, a2, b2, c2, d2, f2, g2, h2, busy2, done2, pass2, fev2;
   logic [4:0] err_count2;
   logic [3:0] fec2;

   e06_response_checker #(.EXP_TABLE(EXP), .SETTLE_CYCLES(1), .LOOP(1'b1)) dut_loop (
      .clk(clk), .rstn(rstn2), .start(start2), .a(a2), .b(b2), .c(c2), .d(d2),
      .f(f2), .g(g2), .h(h2), .busy(busy2), .done(done2), .pass(pass2),
      .err_count(err_count2), .first_err_valid(fev2), .first_err_code(fec2));

   assign {f2, g2, h2} = golden({a2, b2, c2, d2});

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   exp_t sb_q[$];

   // Reference: walk every code, apply the fault to the ideal unit, count differences.
   function automatic exp_t expect_sweep(input longint t0);
      exp_t e;
      e.errs = 0; e.fev = 0; e.fcode = 0;
      for (int k = 0; k < 16; k++) begin
         logic [2:0] r;
         r = golden(4'(k)) ^ fault_mask[k];
         if (stuck_h) r[0] = 1'b0;
         if (r != golden(4'(k))) begin
            if (!e.fev) begin e.fev = 1; e.fcode = k; end
            e.errs++;
         end
      end
      e.pass = (e.errs == 0);
      e.done_cyc = t0 + 1 + 64;
      return e;
   endfunction

   // Monitor: pops one expectation per rising done.
   logic done_prev = 1'b0;
   always @(negedge clk) begin
      if (rstn) begin
         if (!done) chk("pass_low_while_not_done", pass, 0);
         if (done && !done_prev) begin
            if (sb_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               exp_t e;
               e = sb_q.pop_front();
               chk("done_latency_cycle", cyc, e.done_cyc);
               chk("err_count", err_count, e.errs);
               chk("first_err_valid", fev, e.fev);
               chk("first_err_code", fec, e.fcode);
               chk("pass", pass, e.pass);
               chk("busy_at_done", busy, 0);
               chk("abcd_hold_15", {a, b, c, d}, 15);
            end
         end
      end
      done_prev = done;
   end

   task automatic issue_start();
      @(negedge clk);
      sb_q.push_back(expect_sweep(cyc));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0) begin
         chk("sweep_timeout", 1, 0);
         sb_q.delete();
      end
   endtask

   task automatic clear_faults();
      for (int k = 0; k < 16; k++) fault_mask[k] = 3'd0;
      stuck_h = 1'b0;
   endtask

   initial begin
      rstn = 1'b0; start = 1'b0; rstn2 = 1'b0; start2 = 1'b0;
      clear_faults();
      repeat (3) @(negedge clk);
      chk("rst_abcd", {a, b, c, d}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_err_count", err_count, 0);
      chk("rst_fev", fev, 0);
      chk("rst_fec", fec, 0);
      rstn = 1'b1;

      // Fault-free unit
      issue_start();
      wait_drain();

      // h stuck at 0
      stuck_h = 1'b1;
      issue_start();
      wait_drain();
      clear_faults();

      // f inverted only at code 11
      fault_mask[11] = 3'b100;
      issue_start();
      wait_drain();
      clear_faults();

      // Extra start pulses while busy must be ignored
      issue_start();
      repeat (3) @(negedge clk);
      start = 1'b1; @(negedge clk); start = 1'b0;
      repeat (14) @(negedge clk);
      start = 1'b1; @(negedge clk); start = 1'b0;
      wait_drain();

      // Randomised fault patterns
      for (int it = 0; it < 6; it++) begin
         for (int k = 0; k < 16; k++)
            fault_mask[k] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
         issue_start();
         wait_drain();
      end

      // Asynchronous reset during SETTLE of code 6, then a fresh sweep
      clear_faults();
      fault_mask[1] = 3'b010;
      fault_mask[9] = 3'b001;
      issue_start();
      begin
         int n;
         n = 0;
         while ({a, b, c, d} != 4'd6 && n < 200) begin
            @(negedge clk);
            n++;
         end
         chk("reach_code6", {a, b, c, d}, 6);
      end
      rstn = 1'b0;
      #1;
      sb_q.delete();
      chk("mid_rst_abcd", {a, b, c, d}, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_pass", pass, 0);
      chk("mid_rst_err_count", err_count, 0);
      chk("mid_rst_fev", fev, 0);
      chk("mid_rst_fec", fec, 0);
      @(negedge clk);
      rstn = 1'b1;
      issue_start();
      wait_drain();

      // LOOP=1, SETTLE_CYCLES=1 instance
      begin
         longint t0, tr1, tr2;
         int n;
         @(negedge clk);
         rstn2 = 1'b1;
         @(negedge clk);
         t0 = cyc;
         start2 = 1'b1;
         @(negedge clk);
         start2 = 1'b0;
         n = 0;
         while (!done2 && n < 200) begin @(negedge clk); n++; end
         tr1 = cyc;
         chk("loop_first_latency", tr1 - t0 - 1, 48);
         chk("loop_pass", pass2, 1);
         chk("loop_err_count", err_count2, 0);
         chk("loop_fev", fev2, 0);
         chk("loop_fec", fec2, 0);
         chk("loop_busy_at_done", busy2, 0);
         @(negedge clk);
         chk("loop_done_drops", done2, 0);
         @(negedge clk);
         chk("loop_code0_again", {a2, b2, c2, d2}, 0);
         n = 0;
         while (!done2 && n < 200) begin @(negedge clk); n++; end
         tr2 = cyc;
         chk("loop_second_done_period", tr2 - tr1, 49);
         chk("loop_second_pass", pass2, 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

endmodule
